// File: rtl/bcd_seg_scan_if.sv
// Display-scanner bus: load/capture inputs from the producer, registered
// active-low segment, decimal-point and anode drives back.
interface bcd_seg_scan_if;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        err;

  modport master (output load, bcd_in, dp_in, input  seg, dp, an, err);
  modport slave  (input  load, bcd_in, dp_in, output seg, dp, an, err);
endinterface

// File: rtl/bcd_seg_scan.sv
// Four-digit BCD to multiplexed 7-segment scanner with registered outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  bcd_seg_scan_if.slave bus
);
  localparam int NUM_DIG = 4;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]              r_div;
  logic [1:0]                 r_idx;
  logic [15:0]                r_bcd;
  logic [NUM_DIG-1:0]         r_dp;
  logic [6:0]                 r_seg;
  logic                       r_dpo;
  logic [NUM_DIG-1:0]         r_an;
  logic                       r_err;
  logic                       w_tick;
  logic [NUM_DIG-1:0][6:0]    w_dig_seg;
  logic [NUM_DIG-1:0]         w_dig_err;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  assign w_tick = (r_div == DIV_LAST);

  // Each digit is decoded in parallel; the scan index only selects one.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    logic [3:0] w_d;
    assign w_d          = r_bcd[4*g +: 4];
    assign w_dig_err[g] = (w_d > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
    if (g == 0) begin : g_keep
      assign w_dig_seg[g] = seg_decode(w_d);
    end else begin : g_blank
      assign w_dig_seg[g] = (r_bcd[15:4*g] == '0) ? 7'b1111111 : seg_decode(w_d);
    end
`else
    assign w_dig_seg[g] = seg_decode(w_d);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
      r_bcd <= '0;
      r_dp  <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick)   r_idx <= r_idx + 2'd1;
      if (bus.load) begin
        r_bcd <= bus.bcd_in;
        r_dp  <= bus.dp_in;
      end
    end
  end

  // Outputs decode the pre-edge index/shadow, so they trail both by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'b1111111;
      r_dpo <= 1'b1;
      r_an  <= 4'b1111;
      r_err <= 1'b0;
    end else begin
      r_seg <= w_dig_seg[r_idx];
      r_dpo <= ~r_dp[r_idx];
      r_an  <= ~(4'b0001 << r_idx);
      r_err <= |w_dig_err;
    end
  end

  assign bus.seg = r_seg;
  assign bus.dp  = r_dpo;
  assign bus.an  = r_an;
  assign bus.err = r_err;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: two instances (REFRESH_DIV 4 and 1) checked against
// a cycle-count based reference model.
module tb_bcd_seg_scan;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_seg_scan_if if0();
  bcd_seg_scan_if if1();

  bcd_seg_scan #(.REFRESH_DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bcd_seg_scan #(.REFRESH_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  // Model state: edges since reset, shadow value, expected {an,seg,dp,err}.
  int          m_t   [2];
  logic [15:0] m_bcd [2];
  logic [3:0]  m_dp  [2];
  logic [12:0] exp_o [2];

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [12:0] model_out(int i);
    int         idx;
    int         d;
    logic [6:0] s;
    logic [3:0] a;
    logic       e;
    idx = (m_t[i] / div_of(i)) % 4;
    d   = int'((m_bcd[i] >> (4 * idx)) & 16'hF);
    s   = (d > 9) ? 7'b0111111 : seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (m_bcd[i] >> (4 * idx)) == 16'h0) s = 7'b1111111;
`endif
    a = 4'b1111;
    a[idx] = 1'b0;
    e = 1'b0;
    for (int k = 0; k < 4; k++)
      if (((m_bcd[i] >> (4 * k)) & 16'hF) > 16'd9) e = 1'b1;
    return {a, s, ~m_dp[i][idx], e};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_bcd[i] = '0; m_dp[i] = '0;
    end
  endtask

  // One clock: sample inputs as the DUT sees them, advance model, settle.
  task automatic step();
    logic        ld [2];
    logic [15:0] b  [2];
    logic [3:0]  p  [2];
    ld[0] = if0.load; b[0] = if0.bcd_in; p[0] = if0.dp_in;
    ld[1] = if1.load; b[1] = if1.bcd_in; p[1] = if1.dp_in;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_o[i] = model_out(i);
      if (ld[i]) begin m_bcd[i] = b[i]; m_dp[i] = p[i]; end
      m_t[i]++;
    end
    #1;
  endtask

  task automatic drive0(input logic ld, input logic [15:0] b, input logic [3:0] p);
    if0.load = ld; if0.bcd_in = b; if0.dp_in = p;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    got = {if0.an, if0.seg, if0.dp, if0.err};
    checks++;
    if (got !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_hold got %h exp %h", got, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    end
    @(negedge clk); rst = 1'b0;
    step();
    got = {if0.an, if0.seg, if0.dp, if0.err};
    checks++;
    if (got !== {4'b1110, 7'b1000000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_first_edge got %h exp %h", got, {4'b1110, 7'b1000000, 1'b1, 1'b0});
    end
    // Mid-scan abort: load something, scan partway, then assert reset between edges.
    drive0(1'b1, 16'h9876, 4'b1111); step(); drive0(1'b0, 16'h0, 4'h0);
    repeat (6) step();
    #3 rst = 1'b1; model_reset();
    #1 got = {if0.an, if0.seg, if0.dp, if0.err};
    checks++;
    if (got !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_async got %h exp %h", got, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    end
    @(posedge clk); #1 got = {if0.an, if0.seg, if0.dp, if0.err};
    checks++;
    if (got !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_over_edge got %h exp %h", got, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    end
    @(negedge clk); rst = 1'b0;
    step();
    checks++;
    if (if0.an !== 4'b1110 || if0.seg !== 7'b1000000) begin
      errors++; $display("FAIL reset_release got an=%b seg=%b exp an=1110 seg=1000000", if0.an, if0.seg);
    end
  endtask

  task automatic test_scan();
    logic [12:0] got;
    drive0(1'b1, 16'h1234, 4'b0000); step(); drive0(1'b0, 16'hFFFF, 4'hF);
    for (int c = 0; c < 24; c++) begin
      step();
      got = {if0.an, if0.seg, if0.dp, if0.err};
      checks++;
      if (got !== exp_o[0]) begin
        errors++; $display("FAIL scan_1234 cyc %0d got %h exp %h", c, got, exp_o[0]);
      end
    end
  endtask

  task automatic test_err();
    logic [12:0] got;
    drive0(1'b1, 16'h00A5, 4'b0000); step(); drive0(1'b0, 16'h0, 4'h0);
    step();
    checks++;
    if (if0.err !== 1'b1) begin
      errors++; $display("FAIL err_set got %b exp 1", if0.err);
    end
    for (int c = 0; c < 16; c++) begin
      step();
      got = {if0.an, if0.seg, if0.dp, if0.err};
      checks++;
      if (got !== exp_o[0]) begin
        errors++; $display("FAIL err_scan cyc %0d got %h exp %h", c, got, exp_o[0]);
      end
    end
    drive0(1'b1, 16'h0005, 4'b0000); step(); drive0(1'b0, 16'h0, 4'h0);
    step();
    checks++;
    if (if0.err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b exp 0", if0.err);
    end
  endtask

  task automatic test_dp();
    logic [12:0] got;
    drive0(1'b1, 16'(($urandom % 10000)), 4'b0100); step(); drive0(1'b0, 16'h0, 4'h0);
    for (int c = 0; c < 16; c++) begin
      step();
      got = {if0.an, if0.seg, if0.dp, if0.err};
      checks++;
      if (got !== exp_o[0] || if0.dp !== (if0.an != 4'b1011)) begin
        errors++; $display("FAIL dp_slot cyc %0d got %h exp %h", c, got, exp_o[0]);
      end
    end
  endtask

  task automatic test_blank();
    logic [12:0] got;
    logic [15:0] vals [2];
    vals[0] = 16'h0050; vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      drive0(1'b1, vals[v], 4'b0000); step(); drive0(1'b0, 16'h0, 4'h0);
      for (int c = 0; c < 16; c++) begin
        step();
        got = {if0.an, if0.seg, if0.dp, if0.err};
        checks++;
        if (got !== exp_o[0]) begin
          errors++; $display("FAIL blank_%h cyc %0d got %h exp %h", vals[v], c, got, exp_o[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got;
    for (int c = 0; c < 200; c++) begin
      drive0(($urandom % 4) == 0, 16'($urandom), 4'($urandom));
      step();
      got = {if0.an, if0.seg, if0.dp, if0.err};
      checks++;
      if (got !== exp_o[0]) begin
        errors++; $display("FAIL random_load cyc %0d got %h exp %h", c, got, exp_o[0]);
      end
    end
    drive0(1'b0, 16'h0, 4'h0);
  endtask

  task automatic test_div1();
    logic [12:0] got;
    for (int c = 0; c < 64; c++) begin
      if1.load = 1'b1; if1.bcd_in = 16'($urandom); if1.dp_in = 4'($urandom);
      step();
      got = {if1.an, if1.seg, if1.dp, if1.err};
      checks++;
      if (got !== exp_o[1] || $countones(if1.an) != 3) begin
        errors++; $display("FAIL div1_follow cyc %0d got %h exp %h", c, got, exp_o[1]);
      end
    end
    if1.load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b0, 16'h0, 4'h0);
    if1.load = 1'b0; if1.bcd_in = 16'h0; if1.dp_in = 4'h0;
    model_reset();
    #12;
    test_reset();
    test_scan();
    test_err();
    test_dp();
    test_blank();
    test_back_to_back();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
